// File: rtl/avmm_pio_arbiter_pkg.sv
// Shared types and constants for the two-master PIO arbiter.
// The optional grant timeout is enabled with the ARB_TIMEOUT_EN macro.
package pio_arb_pkg;
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_GNT0 = 2'd1,
    ARB_GNT1 = 2'd2
  } arb_state_t;

  localparam logic M_CORE = 1'b0;
  localparam logic M_JTAG = 1'b1;

  localparam int          DEF_TIMEOUT_CYCLES = 256;
  localparam logic [31:0] DEF_TIMEOUT_RDATA  = 32'hDEAD_BEEF;
endpackage

// File: rtl/avmm_pio_arbiter_if.sv
// One Avalon-MM link: the master modport drives the command, the slave modport answers.
interface avmm_pio_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] be;
  logic [DATA_W-1:0]   rdata;
  logic                waitreq;

  modport master (output address, read, write, wdata, be, input rdata, waitreq);
  modport slave  (input address, read, write, wdata, be, output rdata, waitreq);
endinterface

// File: rtl/avmm_pio_arbiter_rr_pick2.sv
// Combinational 2-way round-robin chooser: on a tie the master that did not win last time goes.
module arb_rr_pick2
  import pio_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_pick,
  output logic       o_valid
);
  always_comb begin
    o_valid = |i_req;
    case (i_req)
      2'b01:   o_pick = M_CORE;
      2'b10:   o_pick = M_JTAG;
      2'b11:   o_pick = ~i_last;
      default: o_pick = M_CORE;
    endcase
  end
endmodule

// File: rtl/avmm_pio_arbiter.sv
// Round-robin arbiter sharing one PIO slave between the core (m0) and JTAG (m1) masters.
// Define ARB_TIMEOUT_EN to force-complete a grant stalled for TIMEOUT_CYCLES cycles.
module avmm_pio_arbiter
  import pio_arb_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
`ifdef ARB_TIMEOUT_EN
  ,
  parameter int                TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter logic [DATA_W-1:0] TIMEOUT_RDATA  = DEF_TIMEOUT_RDATA
`endif
) (
  input  logic               clk,
  input  logic               reset,
  avmm_pio_arbiter_if.slave  m0,
  avmm_pio_arbiter_if.slave  m1,
  avmm_pio_arbiter_if.master s,
  output logic [1:0]         grant,
  output logic               err_timeout
);
  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  logic                r_last;
  logic                w_last_nxt;
  logic                w_pick;
  logic                w_pick_valid;
  logic                w_granted;
  logic                w_sel1;
  logic                w_rd_sel;
  logic                w_wr_sel;
  logic                w_req_sel;
  logic                w_to_fire;
  logic [ADDR_W-1:0]   w_addr_sel;
  logic [DATA_W-1:0]   w_wdata_sel;
  logic [DATA_W/8-1:0] w_be_sel;
  logic [DATA_W-1:0]   w_rdata_gnt;
  logic                w_wait_gnt;

  arb_rr_pick2 u_pick (
    .i_req   ({m1.read | m1.write, m0.read | m0.write}),
    .i_last  (r_last),
    .o_pick  (w_pick),
    .o_valid (w_pick_valid)
  );

  assign w_granted   = (r_state != ARB_IDLE);
  assign w_sel1      = (r_state == ARB_GNT1);
  assign w_rd_sel    = w_sel1 ? m1.read : m0.read;
  assign w_wr_sel    = w_sel1 ? m1.write : m0.write;
  assign w_req_sel   = w_rd_sel | w_wr_sel;
  assign w_addr_sel  = w_sel1 ? m1.address : m0.address;
  assign w_wdata_sel = w_sel1 ? m1.wdata : m0.wdata;
  assign w_be_sel    = w_sel1 ? m1.be : m0.be;
  assign grant       = {r_state == ARB_GNT1, r_state == ARB_GNT0};

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  // Stall counter: restarts at every grant, counts cycles the slave holds off the owner.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_state == ARB_IDLE) begin
      r_cnt <= '0;
    end else if (w_req_sel && s.waitreq) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Sticky timeout flag; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_to_fire) begin
      r_err <= 1'b1;
    end else begin
      r_err <= r_err;
    end
  end

  assign w_to_fire   = w_granted && w_req_sel && s.waitreq &&
                       (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign w_rdata_gnt = (w_to_fire && w_rd_sel && !w_wr_sel) ? TIMEOUT_RDATA : s.rdata;
  assign err_timeout = r_err;
`else
  assign w_to_fire   = 1'b0;
  assign w_rdata_gnt = s.rdata;
  assign err_timeout = 1'b0;
`endif

  assign w_wait_gnt = s.waitreq & ~w_to_fire;

  // State and round-robin history registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ARB_IDLE;
      r_last  <= M_JTAG;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // Next-state: a dropped request returns to IDLE without touching the round-robin history.
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    case (r_state)
      ARB_IDLE: begin
        if (w_pick_valid) begin
          w_state_nxt = w_pick ? ARB_GNT1 : ARB_GNT0;
        end else begin
          w_state_nxt = ARB_IDLE;
        end
      end
      ARB_GNT0, ARB_GNT1: begin
        if (!w_req_sel) begin
          w_state_nxt = ARB_IDLE;
        end else if (!s.waitreq || w_to_fire) begin
          w_state_nxt = ARB_IDLE;
          w_last_nxt  = w_sel1 ? M_JTAG : M_CORE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  // Bus muxes; write wins when a master raises read and write together.
  always_comb begin
    s.address  = w_addr_sel;
    s.wdata    = w_wdata_sel;
    s.be       = w_be_sel;
    s.read     = w_granted & w_rd_sel & ~w_wr_sel & ~w_to_fire;
    s.write    = w_granted & w_wr_sel & ~w_to_fire;
    m0.waitreq = 1'b1;
    m0.rdata   = '0;
    m1.waitreq = 1'b1;
    m1.rdata   = '0;
    case (r_state)
      ARB_GNT0: begin
        m0.waitreq = w_wait_gnt;
        m0.rdata   = w_rdata_gnt;
      end
      ARB_GNT1: begin
        m1.waitreq = w_wait_gnt;
        m1.rdata   = w_rdata_gnt;
      end
      default: begin
        m0.waitreq = 1'b1;
        m1.waitreq = 1'b1;
      end
    endcase
  end
endmodule

// File: tb/tb_avmm_pio_arbiter.sv
// Directed-vector bench for avmm_pio_arbiter; builds with or without ARB_TIMEOUT_EN.
module tb_avmm_pio_arbiter;
  logic clk;
  logic reset;
  logic [1:0] grant;
  logic err_timeout;
  int checks;
  int failures;

  avmm_pio_arbiter_if #(.ADDR_W(4), .DATA_W(32)) m0if ();
  avmm_pio_arbiter_if #(.ADDR_W(4), .DATA_W(32)) m1if ();
  avmm_pio_arbiter_if #(.ADDR_W(4), .DATA_W(32)) sif ();

`ifdef ARB_TIMEOUT_EN
  avmm_pio_arbiter #(.ADDR_W(4), .DATA_W(32), .TIMEOUT_CYCLES(16), .TIMEOUT_RDATA(32'hDEAD_BEEF)) dut (
`else
  avmm_pio_arbiter #(.ADDR_W(4), .DATA_W(32)) dut (
`endif
    .clk(clk), .reset(reset), .m0(m0if), .m1(m1if), .s(sif),
    .grant(grant), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic m0_rd, m0_wr, m1_rd, m1_wr;
    logic [3:0] m0_addr, m1_addr;
    logic [31:0] m0_wd, m1_wd, s_rd;
    logic [1:0] e_grant;
    logic e_sread, e_swrite;
    logic [3:0] e_saddr;
    logic [31:0] e_swdata;
    logic [3:0] e_sbe;
    logic e_m0w, e_m1w;
    logic [31:0] e_m0rd, e_m1rd;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    m0if.read = 1'b0; m0if.write = 1'b0;
    m1if.read = 1'b0; m1if.write = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    clear_reqs();
    m0if.address = 4'd0; m0if.wdata = 32'd0; m0if.be = 4'hF;
    m1if.address = 4'd0; m1if.wdata = 32'd0; m1if.be = 4'h3;
    sif.rdata = 32'd0; sif.waitreq = 1'b0;

    //            m0r   m0w   m1r   m1w   a0    a1    wd0           wd1           s_rdata         grant  srd   swr   saddr swdata        sbe   m0w   m1w   m0rd            m1rd
    vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 4'd0, 32'h0000_03FF, 32'h0,        32'hAAAA_0001, 2'b01, 1'b0, 1'b1, 4'd2, 32'h0000_03FF, 4'hF, 1'b0, 1'b1, 32'hAAAA_0001, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd5, 32'h0,        32'h0000_0055, 32'h0000_5A5A, 2'b10, 1'b1, 1'b0, 4'd5, 32'h0000_0055, 4'h3, 1'b1, 1'b0, 32'h0,         32'h0000_5A5A};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 4'd7, 32'h0000_0010, 32'h0000_0020, 32'hCAFE_0001, 2'b01, 1'b1, 1'b0, 4'd1, 32'h0000_0010, 4'hF, 1'b0, 1'b1, 32'hCAFE_0001, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 4'd7, 32'h0000_0010, 32'h0000_0020, 32'hCAFE_0002, 2'b10, 1'b1, 1'b0, 4'd7, 32'h0000_0020, 4'h3, 1'b1, 1'b0, 32'h0,         32'hCAFE_0002};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd3, 32'h0,        32'h0000_0077, 32'h0000_0099, 2'b10, 1'b0, 1'b1, 4'd3, 32'h0000_0077, 4'h3, 1'b1, 1'b0, 32'h0,         32'h0000_0099};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd9, 4'd4, 32'h0000_0099, 32'h0000_0044, 32'h0000_0011, 2'b01, 1'b0, 1'b1, 4'd9, 32'h0000_0099, 4'hF, 1'b0, 1'b1, 32'h0000_0011, 32'h0};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd8, 4'hA, 32'h0000_0088, 32'h0000_00AA, 32'h0000_0022, 2'b10, 1'b1, 1'b0, 4'hA, 32'h0000_00AA, 4'h3, 1'b1, 1'b0, 32'h0,         32'h0000_0022};

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_grant", {30'd0, grant}, 32'd0);
    chk("rst_err", {31'd0, err_timeout}, 32'd0);
    chk("rst_sread", {31'd0, sif.read}, 32'd0);
    chk("rst_swrite", {31'd0, sif.write}, 32'd0);
    chk("rst_m0wait", {31'd0, m0if.waitreq}, 32'd1);
    chk("rst_m1wait", {31'd0, m1if.waitreq}, 32'd1);
    chk("rst_m0rdata", m0if.rdata, 32'd0);
    chk("rst_m1rdata", m1if.rdata, 32'd0);
    tick();

    for (int i = 0; i < 7; i++) begin
      m0if.read = vecs[i].m0_rd; m0if.write = vecs[i].m0_wr;
      m1if.read = vecs[i].m1_rd; m1if.write = vecs[i].m1_wr;
      m0if.address = vecs[i].m0_addr; m1if.address = vecs[i].m1_addr;
      m0if.wdata = vecs[i].m0_wd; m1if.wdata = vecs[i].m1_wd;
      sif.rdata = vecs[i].s_rd;
      @(negedge clk);
      chk($sformatf("v%0d_idle_grant", i), {30'd0, grant}, 32'd0);
      tick();
      @(negedge clk);
      chk($sformatf("v%0d_grant", i), {30'd0, grant}, {30'd0, vecs[i].e_grant});
      chk($sformatf("v%0d_sread", i), {31'd0, sif.read}, {31'd0, vecs[i].e_sread});
      chk($sformatf("v%0d_swrite", i), {31'd0, sif.write}, {31'd0, vecs[i].e_swrite});
      chk($sformatf("v%0d_saddr", i), {28'd0, sif.address}, {28'd0, vecs[i].e_saddr});
      chk($sformatf("v%0d_swdata", i), sif.wdata, vecs[i].e_swdata);
      chk($sformatf("v%0d_sbe", i), {28'd0, sif.be}, {28'd0, vecs[i].e_sbe});
      chk($sformatf("v%0d_m0wait", i), {31'd0, m0if.waitreq}, {31'd0, vecs[i].e_m0w});
      chk($sformatf("v%0d_m1wait", i), {31'd0, m1if.waitreq}, {31'd0, vecs[i].e_m1w});
      chk($sformatf("v%0d_m0rdata", i), m0if.rdata, vecs[i].e_m0rd);
      chk($sformatf("v%0d_m1rdata", i), m1if.rdata, vecs[i].e_m1rd);
      tick();
      clear_reqs();
    end

    // Contention with held requests: m0 in cycle 1, IDLE in cycle 2, m1 in cycle 3.
    m0if.read = 1'b1; m0if.address = 4'd1;
    m1if.read = 1'b1; m1if.address = 4'd2;
    sif.rdata = 32'h0BAD_0000;
    @(negedge clk);
    chk("cont_c0_grant", {30'd0, grant}, 32'd0);
    tick();
    @(negedge clk);
    chk("cont_c1_grant", {30'd0, grant}, 32'd1);
    chk("cont_c1_m0wait", {31'd0, m0if.waitreq}, 32'd0);
    chk("cont_c1_m1wait", {31'd0, m1if.waitreq}, 32'd1);
    tick();
    m0if.read = 1'b0;
    @(negedge clk);
    chk("cont_c2_grant", {30'd0, grant}, 32'd0);
    chk("cont_c2_m1wait", {31'd0, m1if.waitreq}, 32'd1);
    tick();
    @(negedge clk);
    chk("cont_c3_grant", {30'd0, grant}, 32'd2);
    chk("cont_c3_m1wait", {31'd0, m1if.waitreq}, 32'd0);
    chk("cont_c3_m0wait", {31'd0, m0if.waitreq}, 32'd1);
    chk("cont_c3_saddr", {28'd0, sif.address}, 32'd2);
    tick();
    clear_reqs();

    // Slave stalls m1 for 5 grant cycles, answers on the 6th.
    m1if.read = 1'b1; m1if.address = 4'd6;
    sif.waitreq = 1'b1; sif.rdata = 32'd0;
    tick();
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("wait_c%0d_grant", k), {30'd0, grant}, 32'd2);
      chk($sformatf("wait_c%0d_m1wait", k), {31'd0, m1if.waitreq}, 32'd1);
      chk($sformatf("wait_c%0d_m0wait", k), {31'd0, m0if.waitreq}, 32'd1);
      tick();
    end
    sif.waitreq = 1'b0; sif.rdata = 32'h0000_1234;
    @(negedge clk);
    chk("wait_c6_m1wait", {31'd0, m1if.waitreq}, 32'd0);
    chk("wait_c6_m1rdata", m1if.rdata, 32'h0000_1234);
    chk("wait_c6_m0wait", {31'd0, m0if.waitreq}, 32'd1);
    tick();
    clear_reqs();

    // Stuck slave on an m0 read.
    m0if.read = 1'b1; m0if.address = 4'd4;
    sif.waitreq = 1'b1; sif.rdata = 32'd0;
    tick();
`ifdef ARB_TIMEOUT_EN
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      chk($sformatf("to_c%0d_m0wait", k), {31'd0, m0if.waitreq}, 32'd1);
      chk($sformatf("to_c%0d_grant", k), {30'd0, grant}, 32'd1);
      tick();
    end
    @(negedge clk);
    chk("to_fire_m0wait", {31'd0, m0if.waitreq}, 32'd0);
    chk("to_fire_m0rdata", m0if.rdata, 32'hDEAD_BEEF);
    chk("to_fire_sread", {31'd0, sif.read}, 32'd0);
    tick();
    clear_reqs();
    @(negedge clk);
    chk("to_after_err", {31'd0, err_timeout}, 32'd1);
    chk("to_after_grant", {30'd0, grant}, 32'd0);
    tick();
`else
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      chk($sformatf("hang_c%0d_m0wait", k), {31'd0, m0if.waitreq}, 32'd1);
      chk($sformatf("hang_c%0d_grant", k), {30'd0, grant}, 32'd1);
      chk($sformatf("hang_c%0d_err", k), {31'd0, err_timeout}, 32'd0);
      tick();
    end
    sif.waitreq = 1'b0;
    @(negedge clk);
    chk("hang_release_m0wait", {31'd0, m0if.waitreq}, 32'd0);
    tick();
    clear_reqs();
`endif

    // m1 abandons a stalled write; the round-robin history must be untouched (m0 served last).
    sif.waitreq = 1'b1;
    m1if.write = 1'b1; m1if.address = 4'd6; m1if.wdata = 32'h0000_00C3;
    tick();
    @(negedge clk);
    chk("viol_c1_grant", {30'd0, grant}, 32'd2);
    chk("viol_c1_m1wait", {31'd0, m1if.waitreq}, 32'd1);
    tick();
    @(negedge clk);
    chk("viol_c2_swrite", {31'd0, sif.write}, 32'd1);
    tick();
    m1if.write = 1'b0;
    @(negedge clk);
    chk("viol_c3_swrite", {31'd0, sif.write}, 32'd0);
    tick();
    sif.waitreq = 1'b0;
    @(negedge clk);
    chk("viol_c4_grant", {30'd0, grant}, 32'd0);
    tick();
    m0if.read = 1'b1; m1if.read = 1'b1;
    tick();
    @(negedge clk);
    chk("viol_tie_grant", {30'd0, grant}, 32'd2);
    tick();
    clear_reqs();
    @(negedge clk);
`ifdef ARB_TIMEOUT_EN
    chk("err_sticky", {31'd0, err_timeout}, 32'd1);
`else
    chk("err_tied", {31'd0, err_timeout}, 32'd0);
`endif
    tick();

    // Asynchronous reset in the middle of a stalled grant.
    m0if.read = 1'b1; m0if.address = 4'd3;
    sif.waitreq = 1'b1;
    tick();
    #1;
    chk("mid_pre_sread", {31'd0, sif.read}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_sread", {31'd0, sif.read}, 32'd0);
    chk("mid_swrite", {31'd0, sif.write}, 32'd0);
    chk("mid_m0wait", {31'd0, m0if.waitreq}, 32'd1);
    chk("mid_m1wait", {31'd0, m1if.waitreq}, 32'd1);
    chk("mid_grant", {30'd0, grant}, 32'd0);
    tick();
    clear_reqs();
    sif.waitreq = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_grant", {30'd0, grant}, 32'd0);
    chk("post_rst_err", {31'd0, err_timeout}, 32'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
